// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================
// Module  : rv32i_pkg
// Brief   : shared rv32i widths, reset PC, opcodes and fetch types
// Revision: 1.0
// ============================================================
package rv32i_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } fetch_entry_t;

  function automatic logic pc_aligned(input logic [XLEN-1:0] pc);
    return (pc[1:0] == 2'b00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================
// Module  : fetch_unit_if
// Brief   : imem request/response, redirect and decoder channels
// Revision: 1.0
// ============================================================
interface fetch_unit_if;

  logic                           o_imem_req_valid;
  logic                           i_imem_req_ready;
  logic [rv32i_pkg::XLEN-1:0]     o_imem_addr;
  logic                           i_imem_resp_valid;
  logic [rv32i_pkg::ILEN-1:0]     i_imem_resp_data;
  logic                           i_redirect_valid;
  logic [rv32i_pkg::XLEN-1:0]     i_redirect_pc;
  logic                           o_inst_valid;
  logic                           i_inst_ready;
  logic [rv32i_pkg::ILEN-1:0]     o_inst;
  logic [rv32i_pkg::XLEN-1:0]     o_inst_pc;
  logic                           o_fault;

  modport master (
    output o_imem_req_valid, o_imem_addr, o_inst_valid, o_inst, o_inst_pc, o_fault,
    input  i_imem_req_ready, i_imem_resp_valid, i_imem_resp_data,
           i_redirect_valid, i_redirect_pc, i_inst_ready
  );

  modport slave (
    input  o_imem_req_valid, o_imem_addr, o_inst_valid, o_inst, o_inst_pc, o_fault,
    output i_imem_req_ready, i_imem_resp_valid, i_imem_resp_data,
           i_redirect_valid, i_redirect_pc, i_inst_ready
  );

endinterface
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================
// Module  : fetch_fifo
// Brief   : synchronous FIFO with flush, occupancy count, empty/full
// Revision: 1.0
// ============================================================
module fetch_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_data,
  output logic [CW-1:0]    o_count,
  output logic             o_empty,
  output logic             o_full
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd;
  logic [AW-1:0]    r_wr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd];

  // A full queue still accepts a push when the head leaves in the same cycle.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= next_ptr(r_wr);
      if (w_pop)  r_rd <= next_ptr(r_rd);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push && !i_flush && !i_rst) r_mem[r_wr] <= i_data;
  end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================
// Module  : fetch_unit
// Brief   : rv32i fetch stage: PC, imem credit issue, redirect flush
// Revision: 1.0
// ============================================================
module fetch_unit
  import rv32i_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              DEPTH    = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  fetch_unit_if.master bus
);

  localparam int              c_CW      = $clog2(DEPTH + 1);
  localparam int              c_SW      = c_CW + 1;
  localparam int              c_DW      = c_CW + 4;
  localparam logic [XLEN-1:0] c_PC_STEP = XLEN'(4);

  fetch_state_t     r_state;
  logic [XLEN-1:0]  r_pc;
  logic [c_DW-1:0]  r_discard;
  logic             r_fault;

  logic [XLEN-1:0]  w_addr_head;
  logic [c_CW-1:0]  w_addr_count;
  logic             w_addr_empty;
  logic             w_addr_full;
  fetch_entry_t     w_entry_in;
  fetch_entry_t     w_entry_out;
  logic [c_CW-1:0]  w_inst_count;
  logic             w_inst_empty;
  logic             w_inst_full;

  logic             w_run;
  logic             w_redirect;
  logic             w_inst_valid;
  logic             w_inst_pop;
  logic [c_SW-1:0]  w_used;
  logic [c_SW-1:0]  w_limit;
  logic             w_req_valid;
  logic             w_req_fire;
  logic             w_resp;
  logic             w_resp_keep;
  logic             w_inst_push;
  logic [c_DW-1:0]  w_discard_flush;

  assign w_run        = (r_state == ST_RUN) && !i_rst;
  assign w_redirect   = bus.i_redirect_valid && w_run;
  assign w_inst_valid = w_run && !w_inst_empty;
  assign w_inst_pop   = w_inst_valid && bus.i_inst_ready && !w_redirect;

  // A slot freed by the decoder this cycle is reusable immediately, which is
  // what sustains one fetch per cycle at DEPTH 2.
  assign w_used      = c_SW'(w_addr_count) + c_SW'(w_inst_count);
  assign w_limit     = c_SW'(DEPTH) + c_SW'(w_inst_pop);
  assign w_req_valid = w_run && !w_redirect && !w_addr_full && (w_used < w_limit);
  assign w_req_fire  = w_req_valid && bus.i_imem_req_ready;

  assign w_resp      = bus.i_imem_resp_valid && w_run;
  assign w_resp_keep = w_resp && !w_redirect && (r_discard == '0) && !w_addr_empty;
  assign w_inst_push = w_resp_keep && (!w_inst_full || w_inst_pop);

  assign w_entry_in.pc   = w_addr_head;
  assign w_entry_in.inst = bus.i_imem_resp_data;

  // Outstanding discards accumulate across back-to-back redirects; a response
  // landing in the redirect cycle retires either an old discard or the oldest
  // in-flight entry, so it is subtracted once.
  assign w_discard_flush = r_discard + c_DW'(w_addr_count) + c_DW'(w_req_fire)
                         - c_DW'(w_resp);

  assign bus.o_imem_req_valid = w_req_valid;
  assign bus.o_imem_addr      = r_pc;
  assign bus.o_inst_valid     = w_inst_valid;
  assign bus.o_inst           = w_inst_valid ? w_entry_out.inst : '0;
  assign bus.o_inst_pc        = w_inst_valid ? w_entry_out.pc   : '0;
  assign bus.o_fault          = r_fault;

  fetch_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_addr_q (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_req_fire),
    .i_data  (r_pc),
    .i_pop   (w_resp_keep),
    .i_flush (w_redirect),
    .o_data  (w_addr_head),
    .o_count (w_addr_count),
    .o_empty (w_addr_empty),
    .o_full  (w_addr_full)
  );

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_inst_q (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_inst_push),
    .i_data  (w_entry_in),
    .i_pop   (w_inst_pop),
    .i_flush (w_redirect),
    .o_data  (w_entry_out),
    .o_count (w_inst_count),
    .o_empty (w_inst_empty),
    .o_full  (w_inst_full)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_RUN;
      r_pc      <= RESET_PC;
      r_discard <= '0;
      r_fault   <= 1'b0;
    end else if (r_state == ST_RUN) begin
      if (w_redirect) begin
        // Low bits are cleared so the request address stays word aligned.
        r_pc      <= {bus.i_redirect_pc[XLEN-1:2], 2'b00};
        r_discard <= w_discard_flush;
        if (!pc_aligned(bus.i_redirect_pc)) begin
          r_state <= ST_FAULT;
          r_fault <= 1'b1;
        end
      end else begin
        if (w_req_fire) r_pc <= r_pc + c_PC_STEP;
        if (w_resp && (r_discard != '0)) r_discard <= r_discard - c_DW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================
// Module  : tb_fetch_unit
// Brief   : directed self-checking bench for fetch_unit
// Revision: 1.0
// ============================================================
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_unit_if bus();

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int lat   = 1;
  int cyc   = 0;
  int fires = 0;
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  logic [31:0] lg_pc[$];
  logic [31:0] lg_inst[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Ends the current cycle: logs handshakes, clocks, then plays memory.
  task automatic cycle();
    logic        f;
    logic [31:0] a;
    #1;
    f = bus.o_imem_req_valid && bus.i_imem_req_ready;
    a = bus.o_imem_addr;
    if (bus.o_inst_valid && bus.i_inst_ready && !bus.i_redirect_valid) begin
      lg_pc.push_back(bus.o_inst_pc);
      lg_inst.push_back(bus.o_inst);
    end
    @(posedge clk);
    #1;
    if (f) begin
      mq_addr.push_back(a);
      mq_due.push_back(cyc + lat);
      fires++;
    end
    cyc++;
    bus.i_redirect_valid  = 1'b0;
    bus.i_imem_resp_valid = 1'b0;
    bus.i_imem_resp_data  = 32'h0;
    if (mq_due.size() > 0 && mq_due[0] == cyc) begin
      bus.i_imem_resp_valid = 1'b1;
      bus.i_imem_resp_data  = mq_addr[0] ^ 32'hDEAD_0000;
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
  endtask

  task automatic reset_on();
    rst = 1'b1;
    bus.i_redirect_valid = 1'b0;
    cycle();
    cycle();
  endtask

  task automatic reset_off();
    mq_addr.delete();
    mq_due.delete();
    lg_pc.delete();
    lg_inst.delete();
    bus.i_imem_resp_valid = 1'b0;
    bus.i_imem_resp_data  = 32'h0;
    rst   = 1'b0;
    cyc   = 0;
    fires = 0;
  endtask

  task automatic redirect(input logic [31:0] pc);
    bus.i_redirect_valid = 1'b1;
    bus.i_redirect_pc    = pc;
  endtask

  initial begin
    bus.i_imem_req_ready  = 1'b1;
    bus.i_imem_resp_valid = 1'b0;
    bus.i_imem_resp_data  = 32'h0;
    bus.i_redirect_valid  = 1'b0;
    bus.i_redirect_pc     = 32'h0;
    bus.i_inst_ready      = 1'b1;

    // Reset values, then streaming with 1-cycle memory
    lat = 1;
    reset_on();
    #1;
    chk("rst_req_valid", 64'(bus.o_imem_req_valid), 64'd0);
    chk("rst_addr",      64'(bus.o_imem_addr),      64'h0);
    chk("rst_inst_valid",64'(bus.o_inst_valid),     64'd0);
    chk("rst_inst",      64'(bus.o_inst),           64'h0);
    chk("rst_inst_pc",   64'(bus.o_inst_pc),        64'h0);
    chk("rst_fault",     64'(bus.o_fault),          64'd0);
    reset_off();
    #1;
    chk("a_first_req",  64'(bus.o_imem_req_valid), 64'd1);
    chk("a_first_addr", 64'(bus.o_imem_addr),      64'h0);
    cycle(); #1;
    chk("a_c1_idle",    64'(bus.o_inst_valid), 64'd0);
    cycle(); #1;
    chk("a_c2_valid",   64'(bus.o_inst_valid), 64'd1);
    chk("a_c2_pc",      64'(bus.o_inst_pc),    64'h0);
    chk("a_c2_inst",    64'(bus.o_inst),       64'hDEAD_0000);
    cycle(); #1;
    chk("a_c3_pc",      64'(bus.o_inst_pc),    64'h4);
    chk("a_c3_inst",    64'(bus.o_inst),       64'hDEAD_0004);
    cycle(); #1;
    chk("a_c4_pc",      64'(bus.o_inst_pc),    64'h8);
    cycle();

    // Decoder stall for 5 cycles: head held, no new requests past credit
    bus.i_inst_ready = 1'b0;
    fires = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("b_stall_valid", 64'(bus.o_inst_valid), 64'd1);
      chk("b_stall_pc",    64'(bus.o_inst_pc),    64'hC);
      cycle();
    end
    chk("b_stall_reqs", 64'(fires), 64'd0);
    bus.i_inst_ready = 1'b1;
    lg_pc.delete();
    lg_inst.delete();
    for (int i = 0; i < 3; i++) cycle();
    chk("b_resume_n",    64'(lg_pc.size()), 64'd3);
    chk("b_resume_pc0",  64'(lg_pc[0]),     64'hC);
    chk("b_resume_inst0",64'(lg_inst[0]),   64'hDEAD_000C);
    chk("b_resume_pc1",  64'(lg_pc[1]),     64'h10);
    chk("b_resume_pc2",  64'(lg_pc[2]),     64'h14);

    // Latency 3, two in flight, redirect to 0x100
    lat = 3;
    reset_on();
    reset_off();
    cycle();
    cycle();
    redirect(32'h0000_0100);
    #1;
    chk("c_redir_noreq", 64'(bus.o_imem_req_valid), 64'd0);
    cycle(); #1;
    chk("c_tgt_req",   64'(bus.o_imem_req_valid), 64'd1);
    chk("c_tgt_addr",  64'(bus.o_imem_addr),      64'h100);
    chk("c_flushed",   64'(bus.o_inst_valid),     64'd0);
    lg_pc.delete();
    lg_inst.delete();
    for (int i = 0; i < 6; i++) cycle();
    chk("c_n",     64'(lg_pc.size()), 64'd2);
    chk("c_pc0",   64'(lg_pc[0]),     64'h100);
    chk("c_inst0", 64'(lg_inst[0]),   64'hDEAD_0100);
    chk("c_pc1",   64'(lg_pc[1]),     64'h104);

    // Redirect coinciding with a response and a ready memory
    lat = 1;
    reset_on();
    reset_off();
    for (int i = 0; i < 3; i++) cycle();
    redirect(32'h0000_0200);
    #1;
    chk("d_redir_noreq", 64'(bus.o_imem_req_valid), 64'd0);
    lg_pc.delete();
    lg_inst.delete();
    cycle(); #1;
    chk("d_flushed",  64'(bus.o_inst_valid),  64'd0);
    chk("d_tgt_addr", 64'(bus.o_imem_addr),   64'h200);
    for (int i = 0; i < 4; i++) cycle();
    chk("d_pc0",   64'(lg_pc[0]),   64'h200);
    chk("d_inst0", 64'(lg_inst[0]), 64'hDEAD_0200);
    chk("d_pc1",   64'(lg_pc[1]),   64'h204);

    // Misaligned redirect faults until reset
    redirect(32'h0000_0102);
    cycle();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("e_fault",      64'(bus.o_fault),          64'd1);
      chk("e_no_req",     64'(bus.o_imem_req_valid), 64'd0);
      chk("e_no_valid",   64'(bus.o_inst_valid),     64'd0);
      cycle();
    end
    reset_on();
    #1;
    chk("e_rst_fault", 64'(bus.o_fault), 64'd0);
    reset_off();
    #1;
    chk("e_restart_req",  64'(bus.o_imem_req_valid), 64'd1);
    chk("e_restart_addr", 64'(bus.o_imem_addr),      64'h0);
    cycle();
    cycle(); #1;
    chk("e_restart_pc",   64'(bus.o_inst_pc),    64'h0);
    chk("e_restart_valid",64'(bus.o_inst_valid), 64'd1);

    // PC wrap across the top of the address space
    redirect(32'hFFFF_FFF8);
    lg_pc.delete();
    lg_inst.delete();
    cycle();
    for (int i = 0; i < 5; i++) cycle();
    chk("f_n",     64'(lg_pc.size()), 64'd3);
    chk("f_pc0",   64'(lg_pc[0]),     64'hFFFF_FFF8);
    chk("f_inst0", 64'(lg_inst[0]),   64'h2152_FFF8);
    chk("f_pc1",   64'(lg_pc[1]),     64'hFFFF_FFFC);
    chk("f_pc2",   64'(lg_pc[2]),     64'h0);
    chk("f_inst2", 64'(lg_inst[2]),   64'hDEAD_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
